// File: rtl/cortex_lb_arb_pkg.sv
// rtl/cortex_lb_arb_pkg.sv - shared types and round-robin pick helper for cortex_lb_arbiter
//
// Contents:
//   arb_state_t      FSM encoding (ARB_IDLE, ARB_WAIT)
//   ARB_MAX_MASTERS  upper bound on requesters the pick helper can scan
//   rr_pick()        first set request at or after ptr, wrapping modulo n

package cortex_lb_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_WAIT
  } arb_state_t;

  localparam int unsigned ARB_MAX_MASTERS = 16;
  localparam int unsigned ARB_IDX_W       = $clog2(ARB_MAX_MASTERS);

  // Scan offsets from highest to lowest so the smallest offset from ptr that
  // hits a set request is the one left standing. Offsets >= n are ignored,
  // which keeps the loop bound constant while n stays a parameter.
  // Returns ptr when nothing is requested; callers qualify with |req.
  function automatic int unsigned rr_pick(
    input logic [ARB_MAX_MASTERS-1:0] req,
    input int unsigned                ptr,
    input int unsigned                n
  );
    int unsigned idx;
    rr_pick = ptr;
    for (int k = ARB_MAX_MASTERS - 1; k >= 0; k--) begin
      idx = ptr + unsigned'(k);
      if (idx >= n) begin
        idx = idx - n;
      end
      if ((unsigned'(k) < n) && req[idx[ARB_IDX_W-1:0]]) begin
        rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/lb_rr_arbiter.sv
// rtl/lb_rr_arbiter.sv - combinational round-robin grant selection
//
// Ports:
//   req      in   NUM_MASTERS  request vector
//   ptr      in   IDX_W        highest-priority index for this decision
//   gnt      out  NUM_MASTERS  one-hot grant (all zero when req is zero)
//   gnt_idx  out  IDX_W        index of the granted requester

module lb_rr_arbiter
  import cortex_lb_arb_pkg::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [IDX_W-1:0]       gnt_idx
);

  logic [ARB_MAX_MASTERS-1:0] req_ext;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_MASTERS-1:0] = req;
    gnt_idx = IDX_W'(rr_pick(req_ext, 32'(ptr), unsigned'(NUM_MASTERS)));
    gnt     = '0;
    if (|req) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cortex_lb_arbiter.sv
// rtl/cortex_lb_arbiter.sv - round-robin sharing of the Cortex local-bus slave port
//
// One transaction in flight. IDLE picks a requester round-robin, latches its
// address/data and fires a one-cycle lb_wr_en/lb_rd_en strobe; WAIT holds the
// latched address/data until the matching lb_*_valid, then pulses the
// requester's done strobe. A watchdog aborts after TIMEOUT_CYCLES WAIT cycles,
// returning DEFAULT_DATA_VAL on reads and pulsing timeout_err.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   mst_wr_en      per-master write request (level, wins over a read)
//   mst_rd_en      per-master read request (level)
//   mst_addr       packed per-master addresses
//   mst_wr_data    packed per-master write data
//   mst_wr_valid   one-cycle write-done pulse to the granted master
//   mst_rd_valid   one-cycle read-done pulse to the granted master
//   mst_rd_data    shared read data, valid with mst_rd_valid
//   lb_wr_en       write strobe to splitter
//   lb_rd_en       read strobe to splitter
//   lb_addr        address to splitter
//   lb_wr_data     write data to splitter
//   lb_wr_valid    write complete from splitter
//   lb_rd_valid    read complete from splitter
//   lb_rd_data     read data from splitter
//   timeout_err    one-cycle pulse on watchdog abort

module cortex_lb_arbiter
  import cortex_lb_arb_pkg::*;
#(
  parameter int                   NUM_MASTERS      = 3,
  parameter int                   LB_DATA_W        = 32,
  parameter int                   LB_ADDR_W        = 16,
  parameter int                   TIMEOUT_CYCLES   = 256,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS-1:0]           mst_wr_en,
  input  logic [NUM_MASTERS-1:0]           mst_rd_en,
  input  logic [NUM_MASTERS*LB_ADDR_W-1:0] mst_addr,
  input  logic [NUM_MASTERS*LB_DATA_W-1:0] mst_wr_data,
  output logic [NUM_MASTERS-1:0]           mst_wr_valid,
  output logic [NUM_MASTERS-1:0]           mst_rd_valid,
  output logic [LB_DATA_W-1:0]             mst_rd_data,
  output logic                             lb_wr_en,
  output logic                             lb_rd_en,
  output logic [LB_ADDR_W-1:0]             lb_addr,
  output logic [LB_DATA_W-1:0]             lb_wr_data,
  input  logic                             lb_wr_valid,
  input  logic                             lb_rd_valid,
  input  logic [LB_DATA_W-1:0]             lb_rd_data,
  output logic                             timeout_err
);

  localparam int                IDX_W   = $clog2(NUM_MASTERS);
  localparam int                WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(NUM_MASTERS - 1);

  arb_state_t             state, state_d;
  logic [IDX_W-1:0]       rr_ptr, rr_ptr_d;
  logic [WD_W-1:0]        wd_cnt, wd_cnt_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [NUM_MASTERS-1:0] gnt_oh_q, gnt_oh_d;
  logic                   is_wr_q, is_wr_d;

  logic [NUM_MASTERS-1:0] mst_wr_valid_d;
  logic [NUM_MASTERS-1:0] mst_rd_valid_d;
  logic [LB_DATA_W-1:0]   mst_rd_data_d;
  logic                   lb_wr_en_d;
  logic                   lb_rd_en_d;
  logic [LB_ADDR_W-1:0]   lb_addr_d;
  logic [LB_DATA_W-1:0]   lb_wr_data_d;
  logic                   timeout_err_d;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IDX_W-1:0]       arb_idx;
  logic                   slv_valid;

  assign req       = mst_wr_en | mst_rd_en;
  // Only the completion matching the latched direction counts.
  assign slv_valid = is_wr_q ? lb_wr_valid : lb_rd_valid;

  lb_rr_arbiter #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_W       (IDX_W)
  ) u_rr (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    wd_cnt_d       = wd_cnt;
    gnt_idx_d      = gnt_idx_q;
    gnt_oh_d       = gnt_oh_q;
    is_wr_d        = is_wr_q;
    mst_wr_valid_d = '0;
    mst_rd_valid_d = '0;
    mst_rd_data_d  = mst_rd_data;
    lb_wr_en_d     = 1'b0;
    lb_rd_en_d     = 1'b0;
    lb_addr_d      = lb_addr;
    lb_wr_data_d   = lb_wr_data;
    timeout_err_d  = 1'b0;

    case (state)
      ARB_IDLE: begin
        // Late responses arriving here are simply not looked at.
        if (|req) begin
          gnt_idx_d    = arb_idx;
          gnt_oh_d     = arb_gnt;
          is_wr_d      = mst_wr_en[arb_idx];
          lb_addr_d    = mst_addr[arb_idx*LB_ADDR_W +: LB_ADDR_W];
          lb_wr_data_d = mst_wr_data[arb_idx*LB_DATA_W +: LB_DATA_W];
          lb_wr_en_d   = mst_wr_en[arb_idx];
          lb_rd_en_d   = ~mst_wr_en[arb_idx];
          wd_cnt_d     = '0;
          state_d      = ARB_WAIT;
        end
      end

      ARB_WAIT: begin
        wd_cnt_d = wd_cnt + 1'b1;
        // Completion is checked before the watchdog so a response landing
        // in the expiry cycle still returns real data.
        if (slv_valid || (wd_cnt == WD_LAST)) begin
          if (is_wr_q) begin
            mst_wr_valid_d = gnt_oh_q;
          end else begin
            mst_rd_valid_d = gnt_oh_q;
            mst_rd_data_d  = slv_valid ? lb_rd_data : DEFAULT_DATA_VAL;
          end
          timeout_err_d = ~slv_valid;
          // The just-served master drops to lowest priority.
          rr_ptr_d      = (gnt_idx_q == IDX_MAX) ? '0 : gnt_idx_q + 1'b1;
          wd_cnt_d      = '0;
          state_d       = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ARB_IDLE;
      rr_ptr       <= '0;
      wd_cnt       <= '0;
      gnt_idx_q    <= '0;
      gnt_oh_q     <= '0;
      is_wr_q      <= 1'b0;
      mst_wr_valid <= '0;
      mst_rd_valid <= '0;
      mst_rd_data  <= '0;
      lb_wr_en     <= 1'b0;
      lb_rd_en     <= 1'b0;
      lb_addr      <= '0;
      lb_wr_data   <= '0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      wd_cnt       <= wd_cnt_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_oh_q     <= gnt_oh_d;
      is_wr_q      <= is_wr_d;
      mst_wr_valid <= mst_wr_valid_d;
      mst_rd_valid <= mst_rd_valid_d;
      mst_rd_data  <= mst_rd_data_d;
      lb_wr_en     <= lb_wr_en_d;
      lb_rd_en     <= lb_rd_en_d;
      lb_addr      <= lb_addr_d;
      lb_wr_data   <= lb_wr_data_d;
      timeout_err  <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_cortex_lb_arbiter.sv
// tb/tb_cortex_lb_arbiter.sv - directed scoreboard bench for cortex_lb_arbiter

module tb_cortex_lb_arbiter;

  localparam int NM = 3;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [NM-1:0]    mst_wr_en;
  logic [NM-1:0]    mst_rd_en;
  logic [NM*AW-1:0] mst_addr;
  logic [NM*DW-1:0] mst_wr_data;
  logic [NM-1:0]    mst_wr_valid;
  logic [NM-1:0]    mst_rd_valid;
  logic [DW-1:0]    mst_rd_data;
  logic             lb_wr_en;
  logic             lb_rd_en;
  logic [AW-1:0]    lb_addr;
  logic [DW-1:0]    lb_wr_data;
  logic             lb_wr_valid;
  logic             lb_rd_valid;
  logic [DW-1:0]    lb_rd_data;
  logic             timeout_err;

  cortex_lb_arbiter #(
    .NUM_MASTERS      (NM),
    .LB_DATA_W        (DW),
    .LB_ADDR_W        (AW),
    .TIMEOUT_CYCLES   (TO),
    .DEFAULT_DATA_VAL (32'hdeadbabe)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mst_wr_en    (mst_wr_en),
    .mst_rd_en    (mst_rd_en),
    .mst_addr     (mst_addr),
    .mst_wr_data  (mst_wr_data),
    .mst_wr_valid (mst_wr_valid),
    .mst_rd_valid (mst_rd_valid),
    .mst_rd_data  (mst_rd_data),
    .lb_wr_en     (lb_wr_en),
    .lb_rd_en     (lb_rd_en),
    .lb_addr      (lb_addr),
    .lb_wr_data   (lb_wr_data),
    .lb_wr_valid  (lb_wr_valid),
    .lb_rd_valid  (lb_rd_valid),
    .lb_rd_data   (lb_rd_data),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NM-1:0] wr_v;
    logic [NM-1:0] rd_v;
    logic [DW-1:0] data;
    logic          to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [NM-1:0] wr_v, input logic [NM-1:0] rd_v,
                          input logic [DW-1:0] data, input logic to);
    exp_t e;
    e.wr_v = wr_v;
    e.rd_v = rd_v;
    e.data = data;
    e.to   = to;
    sb.push_back(e);
  endtask

  // Every master-side done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if ((|mst_wr_valid) || (|mst_rd_valid) || timeout_err) begin
      if (sb.size() == 0) begin
        check("spurious_wr_valid", 64'(mst_wr_valid), 64'd0);
        check("spurious_rd_valid", 64'(mst_rd_valid), 64'd0);
        check("spurious_timeout", 64'(timeout_err), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_wr_valid", 64'(mst_wr_valid), 64'(mon_e.wr_v));
        check("done_rd_valid", 64'(mst_rd_valid), 64'(mon_e.rd_v));
        check("done_timeout", 64'(timeout_err), 64'(mon_e.to));
        if (|mon_e.rd_v) begin
          check("done_rd_data", 64'(mst_rd_data), 64'(mon_e.data));
        end
      end
    end
  end

  task automatic set_req(input int m, input logic [AW-1:0] a, input logic [DW-1:0] d);
    mst_addr[m*AW +: AW]    = a;
    mst_wr_data[m*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    mst_wr_en   = '0;
    mst_rd_en   = '0;
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(lb_wr_en || lb_rd_en) && n < 20);
    check("strobe_seen", 64'(lb_wr_en | lb_rd_en), 64'd1);
  endtask

  // Acts as the splitter for one transaction of master m. lat is the number
  // of cycles after the strobe cycle before the valid; lat < 0 never answers.
  task automatic serve(input int m, input bit wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input int lat,
                       input logic [DW-1:0] rdata, input bit drop);
    int n;
    wait_strobe();
    check("strobe_wr", 64'(lb_wr_en), 64'(wr));
    check("strobe_rd", 64'(lb_rd_en), 64'(!wr));
    check("strobe_addr", 64'(lb_addr), 64'(addr));
    if (wr) check("strobe_wdata", 64'(lb_wr_data), 64'(wdata));
    if (lat >= 2) begin
      if (wr) lb_rd_valid = 1'b1;
      else    lb_wr_valid = 1'b1;
    end
    if (lat >= 0) begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        lb_wr_valid = 1'b0;
        lb_rd_valid = 1'b0;
        if (k == 1) check("strobe_one_cycle", 64'(lb_wr_en | lb_rd_en), 64'd0);
      end
      if (wr) begin
        lb_wr_valid = 1'b1;
      end else begin
        lb_rd_valid = 1'b1;
        lb_rd_data  = rdata;
      end
      @(negedge clk);
      lb_wr_valid = 1'b0;
      lb_rd_valid = 1'b0;
      check("done_pulse", 64'(wr ? mst_wr_valid[m] : mst_rd_valid[m]), 64'd1);
    end else begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (n == 1) check("strobe_one_cycle", 64'(lb_wr_en | lb_rd_en), 64'd0);
      end while (!(mst_wr_valid[m] || mst_rd_valid[m]) && n < 40);
      check("timeout_latency", 64'(n), 64'(TO));
    end
    if (drop) begin
      if (wr) mst_wr_en[m] = 1'b0;
      else    mst_rd_en[m] = 1'b0;
    end
  endtask

  initial begin
    rst         = 1'b1;
    mst_wr_en   = '0;
    mst_rd_en   = '0;
    mst_addr    = '0;
    mst_wr_data = '0;
    lb_wr_valid = 1'b0;
    lb_rd_valid = 1'b0;
    lb_rd_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_lb_wr_en", 64'(lb_wr_en), 64'd0);
    check("rst_lb_rd_en", 64'(lb_rd_en), 64'd0);
    check("rst_lb_addr", 64'(lb_addr), 64'd0);
    check("rst_mst_wr_valid", 64'(mst_wr_valid), 64'd0);
    check("rst_mst_rd_valid", 64'(mst_rd_valid), 64'd0);
    check("rst_mst_rd_data", 64'(mst_rd_data), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);
    rst = 1'b0;

    // M1 write, slave answers two cycles after the strobe.
    set_req(1, 16'h0010, 32'h12345678);
    push_exp(3'b010, 3'b000, 32'h0, 1'b0);
    mst_wr_en[1] = 1'b1;
    serve(1, 1'b1, 16'h0010, 32'h12345678, 2, 32'h0, 1'b1);

    // Three simultaneous reads from reset come out M0, M1, M2.
    do_reset();
    for (int m = 0; m < NM; m++) set_req(m, 16'h0100 + 16'(m), 32'h0);
    push_exp(3'b000, 3'b001, 32'hA0, 1'b0);
    push_exp(3'b000, 3'b010, 32'hA1, 1'b0);
    push_exp(3'b000, 3'b100, 32'hA2, 1'b0);
    mst_rd_en = 3'b111;
    serve(0, 1'b0, 16'h0100, 32'h0, 0, 32'hA0, 1'b1);
    serve(1, 1'b0, 16'h0101, 32'h0, 1, 32'hA1, 1'b1);
    serve(2, 1'b0, 16'h0102, 32'h0, 3, 32'hA2, 1'b1);

    // M0 keeps reading, M2 asks once: M0, M2, M0.
    push_exp(3'b000, 3'b001, 32'hB0, 1'b0);
    push_exp(3'b000, 3'b100, 32'hB2, 1'b0);
    push_exp(3'b000, 3'b001, 32'hB3, 1'b0);
    mst_rd_en = 3'b101;
    serve(0, 1'b0, 16'h0100, 32'h0, 1, 32'hB0, 1'b0);
    serve(2, 1'b0, 16'h0102, 32'h0, 0, 32'hB2, 1'b1);
    serve(0, 1'b0, 16'h0100, 32'h0, 2, 32'hB3, 1'b1);

    // M1 read never answered: watchdog returns the default and flags it.
    push_exp(3'b000, 3'b010, 32'hdeadbabe, 1'b1);
    mst_rd_en[1] = 1'b1;
    serve(1, 1'b0, 16'h0101, 32'h0, -1, 32'h0, 1'b1);
    lb_rd_valid = 1'b1;
    @(negedge clk);
    lb_rd_valid = 1'b0;
    check("late_valid_dropped", 64'(mst_rd_valid), 64'd0);

    // Response in the expiry cycle wins over the watchdog.
    push_exp(3'b000, 3'b010, 32'h55AA55AA, 1'b0);
    mst_rd_en[1] = 1'b1;
    serve(1, 1'b0, 16'h0101, 32'h0, TO - 1, 32'h55AA55AA, 1'b1);

    // Write and read both raised on M0: write first, read stays pending.
    set_req(0, 16'h0200, 32'hCAFEF00D);
    push_exp(3'b001, 3'b000, 32'h0, 1'b0);
    push_exp(3'b000, 3'b001, 32'hC0, 1'b0);
    mst_wr_en[0] = 1'b1;
    mst_rd_en[0] = 1'b1;
    serve(0, 1'b1, 16'h0200, 32'hCAFEF00D, 1, 32'h0, 1'b1);
    serve(0, 1'b0, 16'h0200, 32'h0, 1, 32'hC0, 1'b1);

    // Reset during the WAIT of an M2 write abandons it silently.
    set_req(2, 16'h0302, 32'h0BADF00D);
    mst_wr_en[2] = 1'b1;
    wait_strobe();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("wait_rst_lb_wr_en", 64'(lb_wr_en), 64'd0);
    check("wait_rst_lb_addr", 64'(lb_addr), 64'd0);
    check("wait_rst_lb_wr_data", 64'(lb_wr_data), 64'd0);
    check("wait_rst_mst_wr_valid", 64'(mst_wr_valid), 64'd0);
    mst_wr_en[2] = 1'b0;
    rst = 1'b0;
    repeat (TO + 2) @(negedge clk);
    check("no_done_after_rst", 64'(mst_wr_valid), 64'd0);

    // After reset the pointer is back at M0 even with M2 competing.
    set_req(0, 16'h0400, 32'h0);
    set_req(2, 16'h0402, 32'h0);
    push_exp(3'b000, 3'b001, 32'hD0, 1'b0);
    push_exp(3'b000, 3'b100, 32'hD2, 1'b0);
    mst_rd_en = 3'b101;
    serve(0, 1'b0, 16'h0400, 32'h0, 0, 32'hD0, 1'b1);
    serve(2, 1'b0, 16'h0402, 32'h0, 0, 32'hD2, 1'b1);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: observed no finish expected finish");
    $fatal(1);
  end

endmodule
